pixel_uart_serializer: RTL and testbench
========================================

Name: pixel_uart_serializer

Overview:
- Final stage of the edge-detection pipeline. Sits directly downstream of the stride-1 average-pooling stage.
- Accepts 8-bit pooled pixels through a valid/ready interface and buffers them in a small FIFO.
- Transmits each pixel as an 8N1 UART frame on a single serial line toward the host.
- The pooling stage does not stall on ready, so the FIFO absorbs bursts and counts any pixel it has to drop.

Parameters:
- CLKS_PER_BIT, 1736, clk_200mhz cycles per UART bit (200 MHz / 115200 baud); must be >= 2.
- FIFO_DEPTH, 16, pixel FIFO entries; must be a power of 2.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk_200mhz  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pixel_in  in  8  pooled pixel from the pooling stage.
- valid_in  in  1  pixel_in valid for this cycle.
- ready_out  out  1  FIFO can accept a pixel; drives the pooling stage's ready_in.
- tx_serial  out  1  UART line; idles high.
- tx_busy  out  1  high whenever the FSM is not in IDLE.
- fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow_cnt  out  16  count of pixels dropped because the FIFO was full; saturates at 0xFFFF.

Behaviour:
- Reset (async, active-low) forces:
  - tx_serial=1, tx_busy=0, fifo_level=0, overflow_cnt=0
  - FSM to IDLE, FIFO pointers to 0
  - any in-flight frame is abandoned immediately; the line goes high without waiting for a clock.
- ready_out = (fifo_level != FIFO_DEPTH), combinational from the registered count.
- Write: when valid_in && ready_out at a rising edge, pixel_in is stored and the count increments.
- Overflow: when valid_in && !ready_out, the pixel is dropped and overflow_cnt increments (saturating). No other state changes.
- Read: only the FSM reads, only in IDLE, and only when fifo_level != 0. A read pops one entry into an 8-bit shift register.
- Simultaneous write and pop: the count is unchanged.
- Full is judged on the registered count at the start of the cycle. A pop in that same cycle does not make a write acceptable.
- Empty FIFO: no pop occurs; the FSM stays in IDLE.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: tx_serial=1. If the FIFO is non-empty, pop, load the shift register and go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit bit index counts 0..7; after bit 7, go to STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state change.
- tx_serial is registered; no combinational path reaches it.
- Latency:
  - A pixel accepted at edge E0 into an empty, idle block makes tx_serial fall on edge E0+1.
  - A frame is 10*CLKS_PER_BIT cycles long.
  - Back-to-back frames are separated by exactly 1 IDLE cycle, so the frame period is 10*CLKS_PER_BIT+1 cycles.
- Data order is strict FIFO order; no reordering and no duplication.

Optional Feature:
- Macro: PIXEL_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles; period is 11*CLKS_PER_BIT+1.
- Undefined:
  - No PARITY state and no parity logic; 8N1 frames as above.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=16):
- Reset asserted mid-frame, asynchronously -> tx_serial=1 with no clock edge; fifo_level=0, overflow_cnt=0, tx_busy=0; the next accepted pixel produces a clean frame.
- Single pixel 0xA5 at edge 0 -> tx_serial falls at edge 1; line reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; tx_busy high for 40 cycles.
- Burst of 20 pixels 0x00..0x13 on consecutive edges 0..19 -> first pop at edge 1; fifo_level=16 after edge 16; ready_out low from then on; pixels 0x11..0x13 dropped; overflow_cnt=3; exactly 17 frames transmitted, carrying 0x00..0x10 in order.
- Two pixels 0xFF, 0x00 back-to-back -> second start bit begins exactly 41 cycles after the first start bit.
- FIFO empties while valid_in is low -> FSM returns to IDLE; tx_serial held high indefinitely; fifo_level=0.
- With PIXEL_UART_PARITY_EN defined, pixel 0x07 -> parity bit 1 before the stop bit; frame length 44 cycles.

Source files
------------

// File: rtl/pixel_uart_serializer.sv
// Pixel FIFO feeding an 8N1 UART transmitter; final stage of the edge-detection pipeline.
// Define PIXEL_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module pixel_uart_serializer #(
    parameter int CLKS_PER_BIT = 1736,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk_200mhz,
    input  logic              reset_n,
    input  logic [7:0]        pixel_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic [ADDR_W:0]   fifo_level,
    output logic [15:0]       overflow_cnt
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

`ifdef PIXEL_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    state_t            state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
`ifdef PIXEL_UART_PARITY_EN
    logic              parity_bit;
`endif

    logic push;
    logic drop;
    logic pop;
    logic baud_done;

    // Full is judged on the registered count, so a pop in the same cycle never admits a write.
    assign ready_out  = (count != LEVEL_FULL);
    assign fifo_level = count;
    assign push       = valid_in && ready_out;
    assign drop       = valid_in && !ready_out;
    assign pop        = (state == IDLE) && (count != '0);
    assign baud_done  = (baud_cnt == BAUD_LAST);

    // NOTE: pixel storage has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clk_200mhz) begin
        if (push) begin
            mem[wr_ptr] <= pixel_in;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
`ifdef PIXEL_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    baud_cnt  <= '0;
                    bit_idx   <= '0;
                    if (pop) begin
                        shift_reg  <= mem[rd_ptr];
`ifdef PIXEL_UART_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        tx_serial  <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= START;
                    end
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        tx_serial <= shift_reg[0];
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef PIXEL_UART_PARITY_EN
                            tx_serial <= parity_bit;
                            state     <= PARITY;
`else
                            tx_serial <= 1'b1;
                            state     <= STOP;
`endif
                        end else begin
                            // Present the next bit while shifting, so the line stays registered.
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx_serial <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef PIXEL_UART_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    baud_cnt  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_uart_serializer.sv
// Self-checking bench for pixel_uart_serializer: cycle-level transaction model plus a UART frame decoder.
module tb_pixel_uart_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef PIXEL_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int PERIOD = FRAME_BITS * CPB + 1;

    logic          clk_200mhz = 1'b0;
    logic          reset_n    = 1'b1;
    logic [7:0]    pixel_in   = 8'h00;
    logic          valid_in   = 1'b0;
    logic          ready_out;
    logic          tx_serial;
    logic          tx_busy;
    logic [AW:0]   fifo_level;
    logic [15:0]   overflow_cnt;

    pixel_uart_serializer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .clk_200mhz   (clk_200mhz),
        .reset_n      (reset_n),
        .pixel_in     (pixel_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .tx_serial    (tx_serial),
        .tx_busy      (tx_busy),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk_200mhz = ~clk_200mhz;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    // Transaction model: FIFO contents, when the transmitter is next free, and the frame on the line.
    logic [7:0] m_fifo[$];
    logic [7:0] m_sent[$];
    int         m_next_ok  = 0;
    int         m_last_pop = 0;
    logic [7:0] m_cur      = 8'h00;
    int         m_ovf      = 0;

    logic       exp_tx;
    logic       exp_busy;
    int         exp_level;
    logic       exp_ready;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       mon_en   = 1'b1;
    logic       mon_prev = 1'b1;

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef PIXEL_UART_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_sent.delete();
        rx_q.delete();
        start_q.delete();
        m_next_ok  = 0;
        m_last_pop = 0;
        m_cur      = 8'h00;
        m_ovf      = 0;
    endtask

    // Drive one clock cycle, advance the model by the rules at that edge, then settle past the edge.
    task automatic step(input logic v, input logic [7:0] pix);
        bit do_pop;
        bit full;
        @(negedge clk_200mhz);
        valid_in = v;
        pixel_in = pix;
        @(posedge clk_200mhz);
        t++;
        do_pop = (t >= m_next_ok) && (m_fifo.size() > 0);
        full   = (m_fifo.size() == DEPTH);
        if (do_pop) begin
            m_cur      = m_fifo.pop_front();
            m_last_pop = t;
            m_next_ok  = t + PERIOD;
            m_sent.push_back(m_cur);
        end
        if (v && !full) m_fifo.push_back(pix);
        else if (v && m_ovf < 65535) m_ovf++;
        exp_busy  = (t < m_next_ok - 1);
        exp_tx    = exp_busy ? frame_bit(m_cur, (t - m_last_pop) / CPB) : 1'b1;
        exp_level = m_fifo.size();
        exp_ready = (m_fifo.size() != DEPTH);
        #1;
    endtask

    function automatic int drain_cycles();
        int wait_free;
        wait_free = (m_next_ok > t) ? (m_next_ok - t) : 0;
        return wait_free + m_fifo.size() * PERIOD + 4;
    endfunction

    // Frame decoder: finds a falling edge on an idle line and samples each bit mid-way.
    initial begin
        logic [7:0] d;
        forever begin
            @(negedge clk_200mhz);
            if (mon_en && reset_n && mon_prev === 1'b1 && tx_serial === 1'b0) begin
                start_q.push_back(t);
                repeat (CPB / 2) @(negedge clk_200mhz);
                checks++;
                if (tx_serial !== 1'b0) begin
                    errors++;
                    $display("FAIL mon_start: line %b, required 0 at t=%0d", tx_serial, t);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_200mhz);
                    d[i] = tx_serial;
                end
`ifdef PIXEL_UART_PARITY_EN
                repeat (CPB) @(negedge clk_200mhz);
                checks++;
                if (tx_serial !== ^d) begin
                    errors++;
                    $display("FAIL mon_parity: got %b, required %b for data %02h", tx_serial, ^d, d);
                end
`endif
                repeat (CPB) @(negedge clk_200mhz);
                checks++;
                if (tx_serial !== 1'b1) begin
                    errors++;
                    $display("FAIL mon_stop: line %b, required 1 at t=%0d", tx_serial, t);
                end
                rx_q.push_back(d);
                mon_prev = 1'b1;
            end else begin
                mon_prev = tx_serial;
            end
        end
    end

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (tx_serial !== 1'b1)  begin errors++; $display("FAIL reset_tx: got %b, required 1", tx_serial); end
        if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
        if (fifo_level !== '0)   begin errors++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
        if (overflow_cnt !== '0) begin errors++; $display("FAIL reset_ovf: got %0d, required 0", overflow_cnt); end
        if (ready_out !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b, required 1", ready_out); end
        @(negedge clk_200mhz);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int busy_cycles = 0;
        step(1'b1, 8'hA5);
        checks++;
        if (fifo_level !== 1 || tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: level %0d tx %b, required level 1 tx 1", fifo_level, tx_serial);
        end
        for (int c = 0; c < PERIOD + 2; c++) begin
            step(1'b0, 8'h00);
            if (tx_busy === 1'b1) busy_cycles++;
            checks += 2;
            if (tx_serial !== exp_tx) begin
                errors++;
                $display("FAIL single_line c=%0d: got %b, required %b", c, tx_serial, exp_tx);
            end
            if (tx_busy !== exp_busy) begin
                errors++;
                $display("FAIL single_busy c=%0d: got %b, required %b", c, tx_busy, exp_busy);
            end
        end
        checks += 2;
        if (busy_cycles != FRAME_BITS * CPB) begin
            errors++;
            $display("FAIL single_busy_len: got %0d, required %0d", busy_cycles, FRAME_BITS * CPB);
        end
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_data: got %0d frames first %02h, required 1 frame A5",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        rx_q.delete();
        m_sent.delete();
    endtask

    task automatic test_burst();
        int n;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i));
            checks += 3;
            if (fifo_level !== (AW+1)'(exp_level)) begin
                errors++;
                $display("FAIL burst_level i=%0d: got %0d, required %0d", i, fifo_level, exp_level);
            end
            if (ready_out !== exp_ready) begin
                errors++;
                $display("FAIL burst_ready i=%0d: got %b, required %b", i, ready_out, exp_ready);
            end
            if (overflow_cnt !== 16'(m_ovf)) begin
                errors++;
                $display("FAIL burst_ovf i=%0d: got %0d, required %0d", i, overflow_cnt, m_ovf);
            end
        end
        checks++;
        if (overflow_cnt !== 16'd3) begin
            errors++;
            $display("FAIL burst_ovf_total: got %0d, required 3", overflow_cnt);
        end
        n = drain_cycles();
        for (int c = 0; c < n; c++) begin
            step(1'b0, 8'h00);
            checks++;
            if (tx_serial !== exp_tx) begin
                errors++;
                $display("FAIL burst_line c=%0d: got %b, required %b", c, tx_serial, exp_tx);
            end
        end
        checks++;
        if (rx_q.size() != 17) begin
            errors++;
            $display("FAIL burst_frames: got %0d, required 17", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < 17; i++) begin
            checks++;
            if (rx_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL burst_order i=%0d: got %02h, required %02h", i, rx_q[i], 8'(i));
            end
        end
        rx_q.delete();
        m_sent.delete();
    endtask

    task automatic test_back_to_back();
        int n;
        start_q.delete();
        step(1'b1, 8'hFF);
        step(1'b1, 8'h00);
        n = drain_cycles();
        for (int c = 0; c < n; c++) step(1'b0, 8'h00);
        checks += 2;
        if (start_q.size() != 2 || (start_q[1] - start_q[0]) != PERIOD) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d starts spacing %0d, required 2 starts spacing %0d",
                     start_q.size(), (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, PERIOD);
        end
        if (rx_q.size() != 2 || rx_q[0] !== 8'hFF || rx_q[1] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_data: got %0d frames, required FF then 00", rx_q.size());
        end
        rx_q.delete();
        m_sent.delete();
    endtask

    task automatic test_empty_idle();
        int bad = 0;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            step(1'b0, 8'h00);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== '0) bad++;
        end
        checks += 2;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_hold: %0d cycles not idle, required 0", bad);
        end
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL idle_frames: got %0d frames, required 0", rx_q.size());
        end
    endtask

    task automatic test_random();
        logic v;
        int   n;
        for (int c = 0; c < 400; c++) begin
            v = ((c / 50) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            step(v, 8'($urandom));
            checks += 5;
            if (tx_serial !== exp_tx)   begin errors++; $display("FAIL rand_line c=%0d: got %b, required %b", c, tx_serial, exp_tx); end
            if (tx_busy !== exp_busy)   begin errors++; $display("FAIL rand_busy c=%0d: got %b, required %b", c, tx_busy, exp_busy); end
            if (fifo_level !== (AW+1)'(exp_level)) begin errors++; $display("FAIL rand_level c=%0d: got %0d, required %0d", c, fifo_level, exp_level); end
            if (ready_out !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d: got %b, required %b", c, ready_out, exp_ready); end
            if (overflow_cnt !== 16'(m_ovf)) begin errors++; $display("FAIL rand_ovf c=%0d: got %0d, required %0d", c, overflow_cnt, m_ovf); end
        end
        n = drain_cycles();
        for (int c = 0; c < n; c++) step(1'b0, 8'h00);
        checks++;
        if (rx_q.size() != m_sent.size()) begin
            errors++;
            $display("FAIL rand_frames: got %0d, required %0d", rx_q.size(), m_sent.size());
        end
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++) begin
            checks++;
            if (rx_q[i] !== m_sent[i]) begin
                errors++;
                $display("FAIL rand_order i=%0d: got %02h, required %02h", i, rx_q[i], m_sent[i]);
            end
        end
        rx_q.delete();
        m_sent.delete();
    endtask

    task automatic test_reset_mid_frame();
        int n;
        mon_en = 1'b0;
        step(1'b1, 8'h3C);
        for (int c = 0; c < 15; c++) step(1'b0, 8'h00);
        checks++;
        if (tx_busy !== 1'b1 || overflow_cnt === 16'd0) begin
            errors++;
            $display("FAIL midrst_pre: busy %b ovf %0d, required busy 1 and nonzero ovf", tx_busy, overflow_cnt);
        end
        @(negedge clk_200mhz);
        #2 reset_n = 1'b0;
        #1;
        checks += 4;
        if (tx_serial !== 1'b1)  begin errors++; $display("FAIL midrst_tx: got %b, required 1", tx_serial); end
        if (tx_busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b, required 0", tx_busy); end
        if (fifo_level !== '0)   begin errors++; $display("FAIL midrst_level: got %0d, required 0", fifo_level); end
        if (overflow_cnt !== '0) begin errors++; $display("FAIL midrst_ovf: got %0d, required 0", overflow_cnt); end
        model_reset();
        @(negedge clk_200mhz);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step(1'b1, 8'h96);
        n = drain_cycles();
        for (int c = 0; c < n; c++) begin
            step(1'b0, 8'h00);
            checks++;
            if (tx_serial !== exp_tx) begin
                errors++;
                $display("FAIL midrst_line c=%0d: got %b, required %b", c, tx_serial, exp_tx);
            end
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h96) begin
            errors++;
            $display("FAIL midrst_data: got %0d frames, required one frame 96", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_empty_idle();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
